card_stream_decoder: RTL and testbench
======================================

Name: card_stream_decoder

Overview:
Sequential, parametrised successor to the combinational card index splitter. Accepts a stream of card codes over a valid/ready handshake and decodes each code to suit/rank by iterative subtraction, so there is no divider and any deck geometry works. Tracks dealt cards to flag duplicates and accumulates a running hand (count, blackjack-style total, bust). Sits between the shuffler/dealer and the game-logic/display blocks.

Parameters:
NUM_SUITS, 4, number of suits.
RANKS_PER_SUIT, 13, ranks per suit.
CODE_W, 6, input code width; must satisfy 2^CODE_W >= DECK_SIZE.
MAX_HAND, 8, maximum cards counted in one hand.
SUM_W, 8, hand total width.
Derived localparams: DECK_SIZE = NUM_SUITS*RANKS_PER_SUIT; SUIT_W = clog2(NUM_SUITS); RANK_W = clog2(RANKS_PER_SUIT); CNT_W = clog2(MAX_HAND+1).

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  in_code is valid
in_ready  out  1  block can accept a code
in_code  in  CODE_W  card index
hand_clear  in  1  one-cycle pulse; clears hand count/total
deck_clear  in  1  one-cycle pulse; clears dealt bitmap
out_valid  out  1  decoded result is valid
out_ready  in  1  consumer accepts result
out_suit  out  SUIT_W  code / RANKS_PER_SUIT
out_rank  out  RANK_W  code % RANKS_PER_SUIT
out_invalid  out  1  code >= DECK_SIZE
out_dup  out  1  card already dealt since last deck_clear
out_overflow  out  1  hand already held MAX_HAND cards
hand_count  out  CNT_W  cards in current hand
hand_total  out  SUM_W  best blackjack total
hand_bust  out  1  hand_total > 21

Behaviour:
- Reset: FSM to IDLE; out_valid, out_suit, out_rank, all flags, hand_count, hand_total, hand_bust = 0; dealt bitmap = 0; in_ready = 1. Reset mid-division aborts with no output.
- FSM IDLE: in_ready = 1. On in_valid&&in_ready, latch code. If code >= DECK_SIZE, go to EMIT with out_invalid = 1, suit/rank = 0. Otherwise set remainder = code, quotient = 0, go to DIV.
- DIV: in_ready = 0. Each cycle, if remainder >= RANKS_PER_SUIT then subtract and increment quotient; else go to EMIT. Latency from accept to out_valid = suit + 2 cycles (code 0 -> 2, code 51 -> 5).
- EMIT entry (one cycle, commit): out_valid = 1; out_dup = dealt[code]; out_overflow = (hand_count == MAX_HAND) and not dup/invalid. If valid and not dup: set dealt[code]. If valid, not dup and not overflow: hand_count += 1 and the card value is added.
- Card value = rank 0 (Ace): 1 and sets has_ace; ranks 1..9: rank+1; rank >= 10: 10. raw_sum saturates at 2^SUM_W-1. hand_total = raw_sum+10 if has_ace and raw_sum+10 <= 21, else raw_sum. hand_bust = hand_total > 21. Outputs are registered and update the cycle after commit.
- EMIT hold: outputs stable while out_ready = 0; in_ready = 0. On out_ready, clear out_valid and go to IDLE; a new code can be accepted the following cycle. There is no pipelining, so at most one code is in flight.
- hand_clear: zeroes hand_count, raw_sum, has_ace. If it coincides with a commit cycle, the clear applies first and the committing card becomes the sole card of the new hand (count = 1).
- deck_clear: zeroes the bitmap. If it coincides with a commit, the committing card is marked dealt afterward. Neither clear affects the FSM or out_* fields.
- Invalid, dup and overflow cards are still emitted; they never change the hand.

Decomposition:
- Shared package card_pkg: default NUM_SUITS/RANKS_PER_SUIT, ACE_RANK = 0, FACE_VALUE = 10, BLACKJACK = 21, FSM state enum {IDLE, DIV, EMIT}, and a card_value function.
- One sub-module: card_hand_accum (count, raw_sum, has_ace, total/bust, clear priority). The FSM and bitmap stay in the top level.

Test Plan:
- Reset, then code 0 -> out_valid after 2 cycles, suit 0, rank 0, hand_count 1, hand_total 11, hand_bust 0.
- Code 51 -> suit 3, rank 12, out_valid exactly 5 cycles after accept; code 52 -> out_invalid = 1, latency 1, hand unchanged.
- Codes 0 then 12 (Ace, King) -> hand_total 21. Then add 25 (rank 12) -> hand_total 21 (ace hard); add 24 (rank 11) -> 31, hand_bust 1.
- Code 7 twice -> second result has out_dup = 1 and hand_count unchanged; after deck_clear, code 7 is accepted clean.
- Hold out_ready = 0 for 10 cycles -> outputs stable, in_ready = 0; release -> in_ready = 1 on the next cycle. With MAX_HAND = 2, a third card -> out_overflow = 1.
- Pulse hand_clear on the commit cycle of code 1 -> hand_count 1, hand_total 2. Assert rst during DIV for code 40 -> no out_valid; all outputs return to 0.

Source files
------------

// File: rtl/card_pkg.sv
// Shared definitions for the card stream decoder slice.
// Holds default deck geometry, blackjack scoring constants, the decoder
// FSM state type and the per-card point value function.
package card_pkg;

    localparam int DEF_NUM_SUITS      = 4;
    localparam int DEF_RANKS_PER_SUIT = 13;

    localparam int unsigned ACE_RANK   = 0;
    localparam int unsigned FACE_VALUE = 10;
    localparam int unsigned BLACKJACK  = 21;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        EMIT
    } state_t;

    // Width needed to hold values 0..n-1, never less than one bit.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Ace counts 1 (soft promotion handled by the hand accumulator),
    // ranks 1..9 count rank+1, everything above counts as a face card.
    function automatic int unsigned card_value(input int unsigned rank);
        if (rank == ACE_RANK)
            return 1;
        else if (rank < FACE_VALUE)
            return rank + 1;
        else
            return FACE_VALUE;
    endfunction

endpackage

// File: rtl/card_hand_accum.sv
// Running hand accumulator.
// Keeps the card count, the hard (aces = 1) sum and an ace-seen flag, and
// publishes the best blackjack total and bust flag as registered outputs.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   hand_clear   - one-cycle pulse, empties the hand
//   commit       - a valid, non-duplicate card is being committed this cycle
//   rank         - rank of the committing card
//   full         - hand already holds MAX_HAND cards (after any clear)
//   hand_count   - cards in the hand
//   hand_total   - best total (one ace promoted to 11 when it fits)
//   hand_bust    - hand_total exceeds 21
module card_hand_accum
    import card_pkg::*;
#(
    parameter int RANK_W   = 4,
    parameter int MAX_HAND = 8,
    parameter int SUM_W    = 8,
    localparam int CNT_W   = width_of(MAX_HAND + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hand_clear,
    input  logic              commit,
    input  logic [RANK_W-1:0] rank,
    output logic              full,
    output logic [CNT_W-1:0]  hand_count,
    output logic [SUM_W-1:0]  hand_total,
    output logic              hand_bust
);

    localparam int unsigned SUM_MAX = (1 << SUM_W) - 1;

    logic [SUM_W-1:0] raw_sum;
    logic             has_ace;

    logic [CNT_W-1:0] base_count;
    logic [CNT_W-1:0] next_count;
    logic [SUM_W-1:0] base_sum;
    logic [SUM_W-1:0] next_sum;
    logic [SUM_W-1:0] next_total;
    logic             base_ace;
    logic             next_ace;
    logic             add;
    int unsigned      card_pts;
    int unsigned      sum_wide;
    int unsigned      soft_total;

    // A clear in the same cycle as a commit is applied first, so the
    // committing card starts the new hand.
    always_comb begin
        base_count = hand_clear ? '0 : hand_count;
        base_sum   = hand_clear ? '0 : raw_sum;
        base_ace   = hand_clear ? 1'b0 : has_ace;

        full = (base_count == CNT_W'(MAX_HAND));
        add  = commit && !full;

        card_pts = '0;
        if (add)
            card_pts = card_value(32'(rank));

        next_count = add ? base_count + CNT_W'(1) : base_count;
        sum_wide   = 32'(base_sum) + card_pts;
        next_sum   = (sum_wide > SUM_MAX) ? '1 : SUM_W'(sum_wide);
        next_ace   = base_ace || (add && (32'(rank) == ACE_RANK));

        // Promoting one ace from 1 to 11 adds FACE_VALUE.
        soft_total = 32'(next_sum) + FACE_VALUE;
        next_total = (next_ace && (soft_total <= BLACKJACK)) ? SUM_W'(soft_total) : next_sum;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hand_count <= '0;
            raw_sum    <= '0;
            has_ace    <= 1'b0;
            hand_total <= '0;
            hand_bust  <= 1'b0;
        end else begin
            hand_count <= next_count;
            raw_sum    <= next_sum;
            has_ace    <= next_ace;
            hand_total <= next_total;
            hand_bust  <= (32'(next_total) > BLACKJACK);
        end
    end

endmodule

// File: rtl/card_stream_decoder.sv
// Streaming card code decoder.
// Accepts one card code at a time, splits it into suit/rank by repeated
// subtraction, flags invalid and duplicate cards against a dealt bitmap,
// and feeds valid cards into a running blackjack hand.
// Ports:
//   clk, rst               - clock, synchronous active-high reset
//   in_valid/in_ready      - input handshake, in_code carries the card index
//   hand_clear, deck_clear - one-cycle pulses clearing hand / dealt bitmap
//   out_valid/out_ready    - output handshake for the decoded result
//   out_suit, out_rank     - code / RANKS_PER_SUIT, code % RANKS_PER_SUIT
//   out_invalid            - code outside the deck
//   out_dup                - card already dealt since the last deck_clear
//   out_overflow           - hand was already full
//   hand_count/total/bust  - running hand state
module card_stream_decoder
    import card_pkg::*;
#(
    parameter int NUM_SUITS      = DEF_NUM_SUITS,
    parameter int RANKS_PER_SUIT = DEF_RANKS_PER_SUIT,
    parameter int CODE_W         = 6,
    parameter int MAX_HAND       = 8,
    parameter int SUM_W          = 8,
    localparam int DECK_SIZE     = NUM_SUITS * RANKS_PER_SUIT,
    localparam int SUIT_W        = width_of(NUM_SUITS),
    localparam int RANK_W        = width_of(RANKS_PER_SUIT),
    localparam int CNT_W         = width_of(MAX_HAND + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] in_code,
    input  logic              hand_clear,
    input  logic              deck_clear,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SUIT_W-1:0] out_suit,
    output logic [RANK_W-1:0] out_rank,
    output logic              out_invalid,
    output logic              out_dup,
    output logic              out_overflow,
    output logic [CNT_W-1:0]  hand_count,
    output logic [SUM_W-1:0]  hand_total,
    output logic              hand_bust
);

    localparam logic [CODE_W:0]   DECK_LIM = (CODE_W + 1)'(DECK_SIZE);
    localparam logic [CODE_W-1:0] RANK_LIM = CODE_W'(RANKS_PER_SUIT);

    state_t            state;
    state_t            next_state;

    logic [CODE_W-1:0] code_q;
    logic [CODE_W-1:0] rem_q;
    logic [SUIT_W-1:0] quo_q;
    logic              invalid_q;
    logic [DECK_SIZE-1:0] dealt;

    logic code_invalid;
    logic rem_small;
    logic commit;
    logic dup_now;
    logic hand_full;
    logic accum_commit;

    assign in_ready     = (state == IDLE);
    assign code_invalid = ({1'b0, in_code} >= DECK_LIM);
    assign rem_small    = (rem_q < RANK_LIM);

    // EMIT is entered with out_valid low; that first cycle is the commit
    // cycle, after which EMIT holds the registered result.
    assign commit       = (state == EMIT) && !out_valid;
    // A coinciding deck_clear empties the bitmap before the lookup.
    assign dup_now      = !invalid_q && !deck_clear && dealt[code_q];
    assign accum_commit = commit && !invalid_q && !dup_now;

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (in_valid)
                    next_state = code_invalid ? EMIT : DIV;
            end
            DIV: begin
                if (rem_small)
                    next_state = EMIT;
            end
            EMIT: begin
                if (out_valid && out_ready)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            code_q       <= '0;
            rem_q        <= '0;
            quo_q        <= '0;
            invalid_q    <= 1'b0;
            dealt        <= '0;
            out_valid    <= 1'b0;
            out_suit     <= '0;
            out_rank     <= '0;
            out_invalid  <= 1'b0;
            out_dup      <= 1'b0;
            out_overflow <= 1'b0;
        end else begin
            if (deck_clear)
                dealt <= '0;

            case (state)
                IDLE: begin
                    if (in_valid) begin
                        code_q    <= in_code;
                        rem_q     <= in_code;
                        quo_q     <= '0;
                        invalid_q <= code_invalid;
                    end
                end
                DIV: begin
                    if (!rem_small) begin
                        rem_q <= rem_q - RANK_LIM;
                        quo_q <= quo_q + SUIT_W'(1);
                    end
                end
                EMIT: begin
                    if (!out_valid) begin
                        out_valid    <= 1'b1;
                        out_suit     <= invalid_q ? '0 : quo_q;
                        out_rank     <= invalid_q ? '0 : rem_q[RANK_W-1:0];
                        out_invalid  <= invalid_q;
                        out_dup      <= dup_now;
                        out_overflow <= hand_full && !invalid_q && !dup_now;
                        // Later assignment wins over the deck_clear above.
                        if (!invalid_q && !dup_now)
                            dealt[code_q] <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    card_hand_accum #(
        .RANK_W   (RANK_W),
        .MAX_HAND (MAX_HAND),
        .SUM_W    (SUM_W)
    ) u_hand (
        .clk        (clk),
        .rst        (rst),
        .hand_clear (hand_clear),
        .commit     (accum_commit),
        .rank       (rem_q[RANK_W-1:0]),
        .full       (hand_full),
        .hand_count (hand_count),
        .hand_total (hand_total),
        .hand_bust  (hand_bust)
    );

endmodule

// File: tb/tb_card_stream_decoder.sv
// Self-checking bench for card_stream_decoder with a queue-based scoreboard.
module tb_card_stream_decoder;

    localparam int NS   = 4;
    localparam int RPS  = 13;
    localparam int CW   = 6;
    localparam int MAXH = 8;
    localparam int SW   = 8;
    localparam int DECK = NS * RPS;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] in_code;
    logic          hand_clear;
    logic          deck_clear;
    logic          out_valid;
    logic          out_ready;
    logic [1:0]    out_suit;
    logic [3:0]    out_rank;
    logic          out_invalid;
    logic          out_dup;
    logic          out_overflow;
    logic [3:0]    hand_count;
    logic [SW-1:0] hand_total;
    logic          hand_bust;

    always #5 clk = ~clk;

    card_stream_decoder #(
        .NUM_SUITS      (NS),
        .RANKS_PER_SUIT (RPS),
        .CODE_W         (CW),
        .MAX_HAND       (MAXH),
        .SUM_W          (SW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_code      (in_code),
        .hand_clear   (hand_clear),
        .deck_clear   (deck_clear),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_suit     (out_suit),
        .out_rank     (out_rank),
        .out_invalid  (out_invalid),
        .out_dup      (out_dup),
        .out_overflow (out_overflow),
        .hand_count   (hand_count),
        .hand_total   (hand_total),
        .hand_bust    (hand_bust)
    );

    typedef struct {
        int suit;
        int rank;
        int inv;
        int dup;
        int ovf;
        int cnt;
        int tot;
        int bust;
        int lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    bit   m_dealt[DECK];
    int   m_cnt;
    int   m_sum;
    int   m_ace;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset_hand();
        m_cnt = 0;
        m_sum = 0;
        m_ace = 0;
    endfunction

    function automatic void model_reset_deck();
        for (int i = 0; i < DECK; i++)
            m_dealt[i] = 1'b0;
    endfunction

    function automatic int model_total();
        return (m_ace != 0 && m_sum + 10 <= 21) ? m_sum + 10 : m_sum;
    endfunction

    function automatic exp_t model_card(input int code, input bit hclr);
        exp_t e;
        int   pts;
        if (hclr)
            model_reset_hand();
        e.inv  = (code >= DECK) ? 1 : 0;
        e.suit = e.inv ? 0 : code / RPS;
        e.rank = e.inv ? 0 : code % RPS;
        e.dup  = (!e.inv && m_dealt[code]) ? 1 : 0;
        e.ovf  = (!e.inv && !e.dup && m_cnt == MAXH) ? 1 : 0;
        if (!e.inv && !e.dup)
            m_dealt[code] = 1'b1;
        if (!e.inv && !e.dup && !e.ovf) begin
            pts = (e.rank == 0) ? 1 : (e.rank <= 9) ? e.rank + 1 : 10;
            m_cnt++;
            m_sum += pts;
            if (m_sum > 255)
                m_sum = 255;
            if (e.rank == 0)
                m_ace = 1;
        end
        e.cnt  = m_cnt;
        e.tot  = model_total();
        e.bust = (e.tot > 21) ? 1 : 0;
        e.lat  = e.inv ? 1 : e.suit + 2;
        return e;
    endfunction

    task automatic send(input int code, input int hold, input bit hclr);
        exp_t e;
        int   lat;
        int   waited;
        waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            check("in_ready_wait", in_ready, 1);
            return;
        end
        in_valid = 1'b1;
        in_code  = CW'(code);
        sb.push_back(model_card(code, hclr));
        @(posedge clk);
        lat = 0;
        @(negedge clk);
        in_valid = 1'b0;
        e = sb[0];
        while (!out_valid && lat < 20) begin
            if (hclr && lat == e.lat - 1)
                hand_clear = 1'b1;
            @(posedge clk);
            lat++;
            @(negedge clk);
            hand_clear = 1'b0;
        end
        e = sb.pop_front();
        check("latency", lat, e.lat);
        check("out_valid", out_valid, 1);
        check("suit", out_suit, e.suit);
        check("rank", out_rank, e.rank);
        check("invalid", out_invalid, e.inv);
        check("dup", out_dup, e.dup);
        check("overflow", out_overflow, e.ovf);
        check("hand_count", hand_count, e.cnt);
        check("hand_total", hand_total, e.tot);
        check("hand_bust", hand_bust, e.bust);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_in_ready", in_ready, 0);
            check("hold_suit", out_suit, e.suit);
            check("hold_rank", out_rank, e.rank);
            check("hold_count", hand_count, e.cnt);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("release_in_ready", in_ready, 1);
        check("release_valid", out_valid, 0);
    endtask

    task automatic pulse_hand_clear();
        @(negedge clk);
        hand_clear = 1'b1;
        @(negedge clk);
        hand_clear = 1'b0;
        model_reset_hand();
        check("hclr_count", hand_count, 0);
        check("hclr_total", hand_total, 0);
    endtask

    task automatic pulse_deck_clear();
        @(negedge clk);
        deck_clear = 1'b1;
        @(negedge clk);
        deck_clear = 1'b0;
        model_reset_deck();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_suit"}, out_suit, 0);
        check({tag, "_rank"}, out_rank, 0);
        check({tag, "_flags"}, {out_invalid, out_dup, out_overflow}, 0);
        check({tag, "_count"}, hand_count, 0);
        check({tag, "_total"}, hand_total, 0);
        check({tag, "_bust"}, hand_bust, 0);
    endtask

    initial begin
        int seen;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_code    = '0;
        hand_clear = 1'b0;
        deck_clear = 1'b0;
        out_ready  = 1'b0;
        model_reset_hand();
        model_reset_deck();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("reset");

        // Ace, then King of the last suit, then an out-of-deck code.
        send(0, 0, 1'b0);
        send(51, 0, 1'b0);
        send(52, 0, 1'b0);

        // Soft 21, hard 21, bust.
        pulse_hand_clear();
        pulse_deck_clear();
        send(0, 0, 1'b0);
        send(12, 0, 1'b0);
        send(25, 0, 1'b0);
        send(24, 0, 1'b0);

        // Duplicate detection and deck clear.
        pulse_hand_clear();
        pulse_deck_clear();
        send(7, 0, 1'b0);
        send(7, 0, 1'b0);
        pulse_deck_clear();
        send(7, 0, 1'b0);

        // Output back-pressure.
        send(3, 10, 1'b0);

        // Fill the hand to MAX_HAND, then overflow, then a duplicate of the overflow card.
        for (int c = 13; c <= 17; c++)
            send(c, 0, 1'b0);
        send(18, 0, 1'b0);
        send(18, 0, 1'b0);

        // Hand clear coinciding with the commit cycle.
        send(1, 0, 1'b1);

        // Random codes including out-of-deck values, with occasional clears.
        for (int k = 0; k < 12; k++) begin
            if (k % 5 == 4)
                pulse_hand_clear();
            if (k == 8)
                pulse_deck_clear();
            send(int'($urandom_range(0, 63)), int'($urandom_range(0, 2)), 1'b0);
        end

        // Reset while code 40 is still being divided.
        @(negedge clk);
        in_valid = 1'b1;
        in_code  = CW'(40);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset_hand();
        model_reset_deck();
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid)
                seen = 1;
        end
        check("rst_mid_div_no_valid", seen, 0);
        check_all_zero("rst_mid_div");
        send(1, 0, 1'b0);

        check("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
